spin_sweep_engine: RTL and testbench
====================================

Name: spin_sweep_engine

Overview:
- Sequential Metropolis sweep controller for a W x H 2D Ising lattice with periodic boundaries, held in an internal 1-bit-per-site register array.
- It is the requesting end of the spin acceptance interface. For each site it computes the local energy term, draws a 12-bit random value from an internal LFSR, presents both to the combinational acceptance unit, samples the accept bit and flips the spin on acceptance.
- Sits between the host control/CSR logic and the acceptance LUT.

Parameters:
- W, 4, lattice width in sites (power of 2, 2..64).
- H, 4, lattice height in sites (power of 2, 2..64).
- SEED, 16'hACE1, LFSR reset value. A SEED of 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a run; ignored while busy=1.
- sweeps  in  8  number of full-lattice sweeps for the run, sampled on start; 0 is treated as 1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the run completes.
- acc_de  out  5  signed local dE presented to the acceptance unit.
- acc_random  out  12  random value, equal to lfsr[11:0].
- acc_enable  out  1  high only in the PROPOSE state.
- acc_result  in  1  accept bit from the acceptance unit (combinational in its inputs).
- rd_addr  in  log2(W*H)  host readout site index = y*W + x.
- rd_spin  out  1  spin at rd_addr, combinational read.

Behaviour:
- Spin encoding: bit 1 = +1, bit 0 = -1.
- Reset (asynchronous, rst_n=0):
  - all spins = 1; lfsr = SEED; state = IDLE.
  - busy = 0, done = 0, acc_enable = 0, acc_de = 0, acc_random = SEED[11:0].
  - Asserting reset mid-run aborts the run with no done pulse.
- FSM states: IDLE, CALC, PROPOSE, UPDATE, FINISH.
  - IDLE: on start=1, latch sweeps, set site index to 0 and sweep count to 0, go to CALC. busy rises in the following cycle.
  - CALC: read site s and its neighbours left, right, up, down, each with modulo wrap.
    - k = number of neighbour spins equal to 1; S = 2k-4.
    - Register acc_de = +S if s=1, -S if s=0. Legal values: -4, -2, 0, 2, 4 in two's complement.
    - Advance the LFSR once (16-bit Galois, mask 16'hB400), then register acc_random from the new value.
  - PROPOSE: acc_enable = 1 for exactly one cycle. acc_result is sampled on the closing edge.
  - UPDATE: if the sampled result is 1, invert spin[site]. Then advance the site index.
    - On wrap past W*H-1: increment the sweep count and reset the index to 0.
    - If the sweep count reaches the latched sweeps, go to FINISH; otherwise go to CALC.
  - FINISH: done = 1 for one cycle, busy falls in the same cycle, go to IDLE.
- Throughput: 3 cycles per site. The start-to-done latency is 3*W*H*sweeps + 2 cycles.
- Updates are in-place and in raster order. A site in CALC sees neighbour values already written earlier in the same sweep.
- A start pulse in FINISH or any busy state is dropped.
- rd_spin reflects writes from the cycle after UPDATE and is valid during a run.
- acc_de and acc_random hold their values outside CALC.

Optional Feature:
- Macro SPIN_SWEEP_MAG_EN.
- Defined:
  - Adds output port magnetization, signed log2(W*H)+2 bits, equal to (number of 1 spins)*2 - W*H.
  - Reset value is W*H.
  - Updated in UPDATE on each flip: -2 for 1->0, +2 for 0->1.
  - Value is valid the cycle after the flip.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
1. Reset, then start with sweeps=1 and acc_result tied to 0 (W=H=4) -> acc_de = 4 on all 16 proposals; no spin changes; done after 50 cycles; rd_spin = 1 everywhere.
2. Reset, then start with sweeps=1 and acc_result tied to 1 -> first four acc_de values are 4, 2, 2, 0; rd_spin(0) = 0 after the first UPDATE.
3. LFSR sequence: with SEED=16'hACE1, the acc_random sequence matches the Galois 16'hB400 model. Check the first 8 values against the golden model.
4. Assert rst_n=0 mid-run (site 7, sweep 0) -> busy=0 immediately; all spins read 1; no done pulse; a new start runs normally.
5. Pulse start again while busy=1 -> ignored; the done count equals 1; the latency equals the single-run value. With sweeps=0, behaviour is identical to sweeps=1.
6. With SPIN_SWEEP_MAG_EN defined and acc_result=1 -> magnetization goes 16 -> 14 after the first flip and always equals 2*popcount(spins) - 16.

Source files
------------

// File: rtl/spin_sweep_engine.sv
// Sequential Metropolis sweep controller for a W x H periodic Ising lattice.
// Optional magnetization output is enabled with SPIN_SWEEP_MAG_EN.
//
// state   | meaning
// IDLE    | waiting for start
// CALC    | local dE of current site, LFSR step, random value registered
// PROPOSE | acc_enable high, accept bit sampled on the closing edge
// UPDATE  | conditional flip, raster advance, sweep accounting
// FINISH  | done pulse, busy low, back to IDLE
module spin_sweep_engine #(
  parameter int          W    = 4,
  parameter int          H    = 4,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [7:0]                   sweeps,
  output logic                         busy,
  output logic                         done,
  output logic [4:0]                   acc_de,
  output logic [11:0]                  acc_random,
  output logic                         acc_enable,
  input  logic                         acc_result,
`ifdef SPIN_SWEEP_MAG_EN
  output logic signed [$clog2(W*H)+1:0] magnetization,
`endif
  input  logic [$clog2(W*H)-1:0]       rd_addr,
  output logic                         rd_spin
);

  localparam int N  = W * H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef enum logic [2:0] {IDLE, CALC, PROPOSE, UPDATE, FINISH} state_t;

  state_t        state;
  logic [N-1:0]  spins;
  logic [15:0]   lfsr;
  logic [AW-1:0] site;
  logic [7:0]    sweeps_q;
  logic [7:0]    sweep_cnt;
  logic          acc_q;

  logic [XW-1:0]     sx, xl, xr;
  logic [YW-1:0]     sy, yu, yd;
  logic [3:0]        nb;
  logic [2:0]        k;
  logic signed [4:0] s_term;
  logic [4:0]        de_next;
  logic [15:0]       lfsr_next;

  // Power-of-2 dimensions let the x/y fields wrap on their own.
  assign sx = site[XW-1:0];
  assign sy = site[AW-1:XW];
  assign xl = sx - XW'(1);
  assign xr = sx + XW'(1);
  assign yu = sy - YW'(1);
  assign yd = sy + YW'(1);

  assign nb      = {spins[{sy, xl}], spins[{sy, xr}], spins[{yu, sx}], spins[{yd, sx}]};
  assign k       = 3'(nb[0]) + 3'(nb[1]) + 3'(nb[2]) + 3'(nb[3]);
  assign s_term  = $signed({1'b0, k, 1'b0}) - 5'sd4;
  assign de_next = spins[site] ? s_term : -s_term;

  assign lfsr_next = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ 16'hB400) : {1'b0, lfsr[15:1]};

  assign rd_spin = spins[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      spins      <= '1;
      lfsr       <= SEED_EFF;
      site       <= '0;
      sweeps_q   <= 8'd1;
      sweep_cnt  <= 8'd0;
      acc_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      acc_enable <= 1'b0;
      acc_de     <= 5'd0;
      acc_random <= SEED_EFF[11:0];
`ifdef SPIN_SWEEP_MAG_EN
      magnetization <= (AW+2)'(N);
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sweeps_q  <= (sweeps == 8'd0) ? 8'd1 : sweeps;
            site      <= '0;
            sweep_cnt <= 8'd0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          acc_de     <= de_next;
          lfsr       <= lfsr_next;
          acc_random <= lfsr_next[11:0];
          acc_enable <= 1'b1;
          state      <= PROPOSE;
        end
        PROPOSE: begin
          acc_q      <= acc_result;
          acc_enable <= 1'b0;
          state      <= UPDATE;
        end
        UPDATE: begin
          if (acc_q) begin
            spins[site] <= ~spins[site];
`ifdef SPIN_SWEEP_MAG_EN
            magnetization <= spins[site] ? (magnetization - (AW+2)'(2))
                                         : (magnetization + (AW+2)'(2));
`endif
          end
          if (site == AW'(N - 1)) begin
            site      <= '0;
            sweep_cnt <= sweep_cnt + 8'd1;
            if (sweep_cnt + 8'd1 == sweeps_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FINISH;
            end else begin
              state <= CALC;
            end
          end else begin
            site  <= site + AW'(1);
            state <= CALC;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spin_sweep_engine.sv
// Directed bench for spin_sweep_engine (4x4 lattice, default seed).
// Magnetization checks are compiled in when SPIN_SWEEP_MAG_EN is defined.
module tb_spin_sweep_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  sweeps = 8'd0;
  logic        acc_result = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic        busy, done, acc_enable, rd_spin;
  logic [4:0]  acc_de;
  logic [11:0] acc_random;
`ifdef SPIN_SWEEP_MAG_EN
  logic signed [5:0] magnetization;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [4:0]  de_log [64];
  logic [11:0] rnd_log [64];
  logic [11:0] rnd_gold [8];
  int n_en, n_done, busy_low, lat;

  always #5 clk = ~clk;

  spin_sweep_engine #(.W(4), .H(4), .SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sweeps(sweeps),
    .busy(busy), .done(done), .acc_de(acc_de), .acc_random(acc_random),
    .acc_enable(acc_enable), .acc_result(acc_result),
`ifdef SPIN_SWEEP_MAG_EN
    .magnetization(magnetization),
`endif
    .rd_addr(rd_addr), .rd_spin(rd_spin)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_spins(input string tag, input logic v);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk(tag, 32'(rd_spin), 32'(v));
    end
    rd_addr = 4'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs one start..done; lat counts cycles inclusive of the start cycle.
  task automatic run(input logic [7:0] sw, input logic res, input bit poke, input bit flipchk);
    int n;
    sweeps = sw;
    acc_result = res;
    rd_addr = 4'd0;
    n_en = 0; n_done = 0; busy_low = 0; lat = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    while (n < 2000) begin
      if (acc_enable) begin
        if (n_en < 64) begin
          de_log[n_en]  = acc_de;
          rnd_log[n_en] = acc_random;
        end
        n_en++;
      end
      if (poke && n == 10) start = 1'b1;
      if (poke && n == 11) start = 1'b0;
      if (flipchk && n == 3) chk("spin0_before_flip", 32'(rd_spin), 32'd1);
      if (flipchk && n == 4) begin
        chk("spin0_after_flip", 32'(rd_spin), 32'd0);
`ifdef SPIN_SWEEP_MAG_EN
        chk("mag_first_flip", {26'd0, magnetization}, 32'h0E);
`endif
      end
      if (done) begin
        n_done++;
        lat = n + 1;
        break;
      end
      if (!busy) busy_low++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("run_done_seen", 32'(n_done), 32'd1);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    // Galois 0xB400 sequence from 0xACE1: E270 7138 389C 1C4E 0E27 B313 ED89 C2C4
    rnd_gold[0] = 12'h270; rnd_gold[1] = 12'h138; rnd_gold[2] = 12'h89C; rnd_gold[3] = 12'hC4E;
    rnd_gold[4] = 12'hE27; rnd_gold[5] = 12'h313; rnd_gold[6] = 12'hD89; rnd_gold[7] = 12'h2C4;

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_acc_enable", 32'(acc_enable), 32'd0);
    chk("rst_acc_de", 32'(acc_de), 32'd0);
    chk("rst_acc_random", 32'(acc_random), 32'hCE1);
    check_spins("rst_spin", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // No acceptances: every site sees four aligned neighbours.
    run(8'd1, 1'b0, 1'b0, 1'b0);
    chk("t1_latency", 32'(lat), 32'd50);
    chk("t1_proposals", 32'(n_en), 32'd16);
    chk("t1_busy_low", 32'(busy_low), 32'd0);
    chk("t1_done_count", 32'(n_done), 32'd1);
    for (int i = 0; i < 16; i++) chk("t1_de", 32'(de_log[i]), 32'h04);
    for (int i = 0; i < 8; i++) chk("t3_random", 32'(rnd_log[i]), 32'(rnd_gold[i]));
    check_spins("t1_spin", 1'b1);
    chk("t1_de_hold", 32'(acc_de), 32'h04);

    // Always accept: in-place raster updates shape the next dE values.
    do_reset();
    run(8'd1, 1'b1, 1'b0, 1'b1);
    chk("t2_de0", 32'(de_log[0]), 32'h04);
    chk("t2_de1", 32'(de_log[1]), 32'h02);
    chk("t2_de2", 32'(de_log[2]), 32'h02);
    chk("t2_de3", 32'(de_log[3]), 32'h00);
    chk("t2_latency", 32'(lat), 32'd50);
    for (int i = 0; i < 8; i++) chk("t2_random", 32'(rnd_log[i]), 32'(rnd_gold[i]));
    check_spins("t2_spin", 1'b0);
`ifdef SPIN_SWEEP_MAG_EN
    chk("mag_all_flipped", {26'd0, magnetization}, 32'h30);
`endif

    // Abort at site 7 of sweep 0.
    do_reset();
    chk("t4_rst_random", 32'(acc_random), 32'hCE1);
    sweeps = 8'd1;
    acc_result = 1'b1;
    dc = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i < 22; i++) begin
      if (done) dc++;
      @(posedge clk);
      #1;
    end
    chk("t4_busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_busy_abort", 32'(busy), 32'd0);
    chk("t4_enable_abort", 32'(acc_enable), 32'd0);
    chk("t4_done_abort", 32'(done), 32'd0);
    chk("t4_no_done", 32'(dc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_spins("t4_spin", 1'b1);
`ifdef SPIN_SWEEP_MAG_EN
    chk("mag_after_abort", {26'd0, magnetization}, 32'h10);
`endif
    run(8'd1, 1'b0, 1'b0, 1'b0);
    chk("t4_rerun_latency", 32'(lat), 32'd50);
    chk("t4_rerun_done", 32'(n_done), 32'd1);

    // Start while busy, sweeps=0, sweeps=2.
    run(8'd1, 1'b0, 1'b1, 1'b0);
    chk("t5_poke_latency", 32'(lat), 32'd50);
    chk("t5_poke_done", 32'(n_done), 32'd1);
    run(8'd0, 1'b0, 1'b0, 1'b0);
    chk("t5_zero_latency", 32'(lat), 32'd50);
    chk("t5_zero_proposals", 32'(n_en), 32'd16);
    run(8'd2, 1'b0, 1'b0, 1'b0);
    chk("t5_two_latency", 32'(lat), 32'd98);
    chk("t5_two_proposals", 32'(n_en), 32'd32);
    chk("t5_two_done", 32'(n_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
